// File: rtl/seq_neuron_mac.sv
// rtl/seq_neuron_mac.sv - sequential fixed-point neuron: serial MAC, bias add, ReLU or PLAN sigmoid
//
// Purpose:
//   Accepts one input vector with its weights and bias. Multiply-accumulates one
//   input per clock and adds the bias. Then it applies the activation selected by
//   ACT_MODE (0 = ReLU, 1 = PLAN sigmoid) and holds the result until it is taken.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input vector valid
//   in_ready   block can accept a vector (IDLE only)
//   in_vec     unsigned inputs, input i at [i*IN_W +: IN_W]
//   w_vec      signed Q.FRAC weights, weight i at [i*W_W +: W_W]
//   bias       unsigned integer bias
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   out_sum    signed pre-activation sum, Q.FRAC, ACC_W bits
//   out_act    activation result, OUT_W bits
//   busy       high whenever not IDLE
module seq_neuron_mac #(
    parameter int N_INPUTS = 2,
    parameter int IN_W     = 2,
    parameter int W_W      = 8,
    parameter int FRAC     = 4,
    parameter int BIAS_W   = 3,
    parameter int OUT_W    = 8,
    parameter int ACT_MODE = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [N_INPUTS*IN_W-1:0]           in_vec,
    input  logic [N_INPUTS*W_W-1:0]            w_vec,
    input  logic [BIAS_W-1:0]                  bias,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [IN_W+W_W+$clog2(N_INPUTS)+BIAS_W:0] out_sum,
    output logic [OUT_W-1:0]                   out_act,
    output logic                               busy
);

    localparam int ACC_W = IN_W + W_W + $clog2(N_INPUTS) + BIAS_W + 1;
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int PROD_W = IN_W + W_W + 1;
    // Sigmoid arithmetic is done with OUT_W extra fraction bits so the
    // right shifts by the segment slopes lose nothing before the final floor.
    localparam int PW = ACC_W + OUT_W;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MAC  = 3'd1;
    localparam logic [2:0] ST_BIAS = 3'd2;
    localparam logic [2:0] ST_ACT  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Segment breakpoints of |acc| in Q.FRAC units: 1.0, 2.375 (19/8) and 5.0.
    localparam logic [ACC_W-1:0] T_ONE  = ACC_W'(1) << FRAC;
    localparam logic [ACC_W-1:0] T_MID  = (ACC_W'(19) << FRAC) >> 3;
    localparam logic [ACC_W-1:0] T_FIVE = ACC_W'(5) << FRAC;

    // Segment offsets scaled by 2^OUT_W, built from shifts of 1.0:
    // 0.5, 0.625 = 1/2+1/8, 0.84375 = 1/2+1/4+1/16+1/32.
    localparam logic [PW-1:0] P_ONE  = PW'(1) << OUT_W;
    localparam logic [PW-1:0] P_MAX  = P_ONE - PW'(1);
    localparam logic [PW-1:0] C_LO   = P_ONE >> 1;
    localparam logic [PW-1:0] C_MID  = (P_ONE >> 1) + (P_ONE >> 3);
    localparam logic [PW-1:0] C_HI   = (P_ONE >> 1) + (P_ONE >> 2) + (P_ONE >> 4) + (P_ONE >> 5);

    logic [2:0]                 state;
    logic [IDX_W-1:0]           idx;
    logic signed [ACC_W-1:0]    acc;
    logic [N_INPUTS*IN_W-1:0]   in_reg;
    logic [N_INPUTS*W_W-1:0]    w_reg;
    logic [BIAS_W-1:0]          bias_reg;

    logic [IN_W-1:0]            in_cur;
    logic signed [W_W-1:0]      w_cur;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]           bias_term;

    logic [ACC_W-1:0]           mag;
    logic [PW-1:0]              mag_wide;
    logic [PW-1:0]              scaled;
    logic [PW-1:0]              p_wide;
    logic [OUT_W-1:0]           p_lo;
    logic [OUT_W-1:0]           sig_val;
    logic [OUT_W-1:0]           relu_val;
    logic [OUT_W-1:0]           act_val;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    // Operand select for the current MAC step.
    always_comb begin
        in_cur = '0;
        w_cur  = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (idx == IDX_W'(i)) begin
                in_cur = in_reg[i*IN_W +: IN_W];
                w_cur  = w_reg[i*W_W +: W_W];
            end
        end
    end

    // Input is zero-extended so the product is a true signed multiply.
    always_comb begin
        prod      = $signed({1'b0, in_cur}) * w_cur;
        prod_ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        bias_term = {{(ACC_W-BIAS_W){1'b0}}, bias_reg} << FRAC;
    end

    // Activation functions evaluated on the final accumulator value.
    always_comb begin
        mag      = acc[ACC_W-1] ? (~acc + ACC_W'(1)) : acc;
        mag_wide = {{OUT_W{1'b0}}, mag};
        scaled   = {mag, {OUT_W{1'b0}}};

        if (mag >= T_FIVE) begin
            p_wide = P_ONE;
        end else if (mag >= T_MID) begin
            p_wide = (scaled >> (FRAC + 5)) + C_HI;
        end else if (mag >= T_ONE) begin
            p_wide = (scaled >> (FRAC + 3)) + C_MID;
        end else begin
            p_wide = (scaled >> (FRAC + 2)) + C_LO;
        end
        p_lo = p_wide[OUT_W-1:0];

        // Negative side mirrors around 0.5: 2^OUT_W - p, which is the
        // OUT_W-bit negation of p (p is never below 2^(OUT_W-1)).
        if (acc[ACC_W-1]) begin
            sig_val = ~p_lo + OUT_W'(1);
        end else if (p_wide >= P_ONE) begin
            sig_val = '1;
        end else begin
            sig_val = p_lo;
        end

        if (acc[ACC_W-1]) begin
            relu_val = '0;
        end else if (mag_wide > P_MAX) begin
            relu_val = '1;
        end else begin
            relu_val = mag[OUT_W-1:0];
        end

        act_val = (ACT_MODE == 0) ? relu_val : sig_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            acc       <= '0;
            in_reg    <= '0;
            w_reg     <= '0;
            bias_reg  <= '0;
            out_sum   <= '0;
            out_act   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_reg   <= in_vec;
                        w_reg    <= w_vec;
                        bias_reg <= bias;
                        acc      <= '0;
                        idx      <= '0;
                        state    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc + prod_ext;
                    if (idx == IDX_W'(N_INPUTS - 1)) begin
                        idx   <= '0;
                        state <= ST_BIAS;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_BIAS: begin
                    acc   <= acc + $signed(bias_term);
                    state <= ST_ACT;
                end
                ST_ACT: begin
                    out_sum   <= acc;
                    out_act   <= act_val;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_neuron_mac.sv
// tb/tb_seq_neuron_mac.sv - directed self-checking bench for seq_neuron_mac
module tb_seq_neuron_mac;

    logic        clk;
    logic        rst;

    // Shared stimulus for the default-size sigmoid and ReLU instances.
    logic        in_valid;
    logic [3:0]  in_vec;
    logic [15:0] w_vec;
    logic [2:0]  bias;
    logic        out_ready;

    logic        s_in_ready, s_out_valid, s_busy;
    logic [14:0] s_out_sum;
    logic [7:0]  s_out_act;
    logic        r_in_ready, r_out_valid, r_busy;
    logic [14:0] r_out_sum;
    logic [7:0]  r_out_act;

    // Eight-input ReLU instance.
    logic        w8_in_valid;
    logic [15:0] w8_in_vec;
    logic [63:0] w8_w_vec;
    logic [2:0]  w8_bias;
    logic        w8_out_ready;
    logic        w8_in_ready, w8_out_valid, w8_busy;
    logic [16:0] w8_out_sum;
    logic [7:0]  w8_out_act;

    int errors;
    int checks;

    seq_neuron_mac #(.ACT_MODE(1)) dut_sig (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_vec(in_vec), .w_vec(w_vec), .bias(bias), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_sum(s_out_sum), .out_act(s_out_act), .busy(s_busy)
    );

    seq_neuron_mac #(.ACT_MODE(0)) dut_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready),
        .in_vec(in_vec), .w_vec(w_vec), .bias(bias), .out_valid(r_out_valid),
        .out_ready(out_ready), .out_sum(r_out_sum), .out_act(r_out_act), .busy(r_busy)
    );

    seq_neuron_mac #(.N_INPUTS(8), .ACT_MODE(0)) dut_wide (
        .clk(clk), .rst(rst), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
        .in_vec(w8_in_vec), .w_vec(w8_w_vec), .bias(w8_bias), .out_valid(w8_out_valid),
        .out_ready(w8_out_ready), .out_sum(w8_out_sum), .out_act(w8_out_act), .busy(w8_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one vector to the default instances and counts edges from the
    // accepting edge until out_valid is seen; lat = -1 if it never comes.
    task automatic send(input logic [3:0] iv, input logic [15:0] wv,
                        input logic [2:0] b, output int lat);
        int guard;
        guard = 0;
        while (!s_in_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        in_vec = iv; w_vec = wv; bias = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!s_out_valid) lat = -1;
    endtask

    // Accepts the pending result for one cycle.
    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", s_in_ready); end
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", s_out_valid); end
        checks++; if (s_out_sum !== 15'd0) begin errors++; $display("FAIL reset_out_sum got=%0d exp=0", s_out_sum); end
        checks++; if (s_out_act !== 8'd0) begin errors++; $display("FAIL reset_out_act got=%0d exp=0", s_out_act); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
        checks++; if (w8_in_ready !== 1'b1) begin errors++; $display("FAIL reset_wide_in_ready got=%b exp=1", w8_in_ready); end
    endtask

    // in=(3,2), w=(1.0,-0.5), bias 1 -> 3.0 = 48 in Q.4; sigmoid 240, ReLU 48.
    task automatic test_basic();
        int lat;
        send(4'b10_11, {8'hF8, 8'h10}, 3'd1, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        checks++; if (s_out_sum !== 15'd48) begin errors++; $display("FAIL basic_sum got=%0d exp=48", s_out_sum); end
        checks++; if (s_out_act !== 8'd240) begin errors++; $display("FAIL basic_sig_act got=%0d exp=240", s_out_act); end
        checks++; if (r_out_act !== 8'd48) begin errors++; $display("FAIL basic_relu_act got=%0d exp=48", r_out_act); end
        checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done got=%b exp=1", s_busy); end
        release_out();
    endtask

    // in=(3,3), w=(-2,-2) -> -12.0 = -192; both activations 0.
    task automatic test_negative();
        int lat;
        logic [14:0] exp_sum;
        exp_sum = -15'sd192;
        send(4'b11_11, {8'hE0, 8'hE0}, 3'd0, lat);
        checks++; if (s_out_sum !== exp_sum) begin errors++; $display("FAIL neg_sum got=%h exp=%h", s_out_sum, exp_sum); end
        checks++; if (r_out_sum !== exp_sum) begin errors++; $display("FAIL neg_relu_sum got=%h exp=%h", r_out_sum, exp_sum); end
        checks++; if (s_out_act !== 8'd0) begin errors++; $display("FAIL neg_sig_act got=%0d exp=0", s_out_act); end
        checks++; if (r_out_act !== 8'd0) begin errors++; $display("FAIL neg_relu_act got=%0d exp=0", r_out_act); end
        release_out();
    endtask

    task automatic test_zero();
        int lat;
        send(4'b01_11, 16'h0000, 3'd0, lat);
        checks++; if (s_out_sum !== 15'd0) begin errors++; $display("FAIL zero_sum got=%0d exp=0", s_out_sum); end
        checks++; if (s_out_act !== 8'd128) begin errors++; $display("FAIL zero_sig_act got=%0d exp=128", s_out_act); end
        checks++; if (r_out_act !== 8'd0) begin errors++; $display("FAIL zero_relu_act got=%0d exp=0", r_out_act); end
        release_out();
    endtask

    // in=(1,0) so acc equals weight 0; exercises the sigmoid segment edges.
    task automatic test_sigmoid_bounds();
        logic [7:0]  wt  [5] = '{8'h50, 8'h26, 8'h25, 8'h10, 8'hFF};
        logic [7:0]  sig [5] = '{8'd255, 8'd235, 8'd234, 8'd192, 8'd124};
        logic [7:0]  rel [5] = '{8'd80, 8'd38, 8'd37, 8'd16, 8'd0};
        logic [14:0] sum [5] = '{15'd80, 15'd38, 15'd37, 15'd16, 15'h7FFF};
        int lat;
        for (int i = 0; i < 5; i++) begin
            send(4'b00_01, {8'h00, wt[i]}, 3'd0, lat);
            checks++; if (s_out_sum !== sum[i]) begin errors++; $display("FAIL bound_sum[%0d] got=%h exp=%h", i, s_out_sum, sum[i]); end
            checks++; if (s_out_act !== sig[i]) begin errors++; $display("FAIL bound_sig[%0d] got=%0d exp=%0d", i, s_out_act, sig[i]); end
            checks++; if (r_out_act !== rel[i]) begin errors++; $display("FAIL bound_relu[%0d] got=%0d exp=%0d", i, r_out_act, rel[i]); end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        send(4'b10_11, {8'hF8, 8'h10}, 3'd1, lat);
        in_vec = 4'b11_11; w_vec = 16'h7F7F; bias = 3'd7; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, s_out_valid); end
            checks++; if (s_out_sum !== 15'd48) begin errors++; $display("FAIL bp_sum[%0d] got=%0d exp=48", c, s_out_sum); end
            checks++; if (s_out_act !== 8'd240) begin errors++; $display("FAIL bp_act[%0d] got=%0d exp=240", c, s_out_act); end
            checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", c, s_in_ready); end
        end
        in_valid = 1'b0;
        release_out();
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", s_out_valid); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", s_in_ready); end
        @(posedge clk); #1;
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL bp_idle_busy got=%b exp=0", s_busy); end
    endtask

    task automatic test_reset_mid();
        int lat;
        // Leave a result registered so the reset has something to clear.
        send(4'b10_11, {8'hF8, 8'h10}, 3'd1, lat);
        release_out();
        in_vec = 4'b11_11; w_vec = {8'hE0, 8'hE0}; bias = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++; if (s_out_sum !== 15'd0) begin errors++; $display("FAIL rstmid_sum got=%0d exp=0", s_out_sum); end
        checks++; if (s_out_act !== 8'd0) begin errors++; $display("FAIL rstmid_act got=%0d exp=0", s_out_act); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", s_busy); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b exp=1", s_in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_partial got=%b exp=0", s_out_valid); end
        send(4'b10_11, {8'hF8, 8'h10}, 3'd1, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rstmid_latency got=%0d exp=4", lat); end
        checks++; if (s_out_act !== 8'd240) begin errors++; $display("FAIL rstmid_act_after got=%0d exp=240", s_out_act); end
        release_out();
    endtask

    // 8 x 3 x 127/16 + 7 -> 3160 in Q.4; ReLU saturates at 255.
    task automatic test_wide();
        int lat;
        w8_in_vec = 16'hFFFF; w8_w_vec = {8{8'h7F}}; w8_bias = 3'd7; w8_in_valid = 1'b1;
        @(posedge clk); #1;
        w8_in_valid = 1'b0;
        lat = 0;
        while (!w8_out_valid && lat < 30) begin
            @(posedge clk); #1; lat++;
        end
        checks++; if (lat !== 10) begin errors++; $display("FAIL wide_latency got=%0d exp=10", lat); end
        checks++; if (w8_out_sum !== 17'd3160) begin errors++; $display("FAIL wide_sum got=%0d exp=3160", w8_out_sum); end
        checks++; if (w8_out_act !== 8'd255) begin errors++; $display("FAIL wide_act got=%0d exp=255", w8_out_act); end
        w8_out_ready = 1'b1;
        @(posedge clk); #1;
        w8_out_ready = 1'b0;
        checks++; if (w8_in_ready !== 1'b1) begin errors++; $display("FAIL wide_in_ready got=%b exp=1", w8_in_ready); end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_vec = '0; w_vec = '0; bias = '0; out_ready = 1'b0;
        w8_in_valid = 1'b0; w8_in_vec = '0; w8_w_vec = '0; w8_bias = '0; w8_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_basic();
        test_negative();
        test_zero();
        test_sigmoid_bounds();
        test_backpressure();
        test_reset_mid();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
